// File: rtl/fifo_pkg.sv
// fifo_pkg: shared types and defaults for param_sync_fifo.
//   DEF_DATA_W / DEF_DEPTH : default word width and depth.
//   ptr_t convention       : every user declares a local
//                            typedef logic [AW:0] ptr_t, which is one bit
//                            wider than the address so the wrap bit can
//                            tell full from empty. def_ptr_t is that type
//                            at the default depth.
//   fifo_flags_t           : registered status flags {full, afull, empty, aempty}.
package fifo_pkg;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_DEPTH  = 256;
  localparam int DEF_AW     = $clog2(DEF_DEPTH);

  typedef logic [DEF_AW:0] def_ptr_t;

  typedef struct packed {
    logic full;
    logic afull;
    logic empty;
    logic aempty;
  } fifo_flags_t;

  localparam fifo_flags_t FLAGS_RST = '{full: 1'b0, afull: 1'b0, empty: 1'b1, aempty: 1'b1};
endpackage

// File: rtl/param_sync_fifo_if.sv
// param_sync_fifo_if: producer/consumer bus for param_sync_fifo.
//   master : drives wr_en, wr_data, rd_en; observes data, status and count.
//   slave  : the FIFO side.
// Optional macro FIFO_ERR_FLAGS_EN adds the sticky ovf/udf error outputs.
interface param_sync_fifo_if
  import fifo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH
);
  localparam int AW = $clog2(DEPTH);

  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              full;
  logic              afull;
  logic              rd_en;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              empty;
  logic              aempty;
  logic [AW:0]       count;
`ifdef FIFO_ERR_FLAGS_EN
  logic              ovf;
  logic              udf;
`endif

  modport master (
    output wr_en, wr_data, rd_en,
    input  full, afull, rd_data, rd_valid, empty, aempty, count
`ifdef FIFO_ERR_FLAGS_EN
    , input ovf, udf
`endif
  );

  modport slave (
    input  wr_en, wr_data, rd_en,
    output full, afull, rd_data, rd_valid, empty, aempty, count
`ifdef FIFO_ERR_FLAGS_EN
    , output ovf, udf
`endif
  );
endinterface

// File: rtl/fifo_ptr.sv
// fifo_ptr: AW+1 bit FIFO address generator.
//   clk, rst : clock, async active-high reset (pointer -> 0)
//   i_inc    : advance pointer by one (wraps naturally)
//   o_ptr    : full pointer including the wrap bit
//   o_addr   : low AW bits, the memory address
module fifo_ptr
  import fifo_pkg::*;
#(
  parameter int AW = DEF_AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_inc,
  output logic [AW:0]   o_ptr,
  output logic [AW-1:0] o_addr
);
  typedef logic [AW:0] ptr_t;

  ptr_t r_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        r_ptr <= '0;
    else if (i_inc) r_ptr <= r_ptr + ptr_t'(1);
  end

  assign o_ptr  = r_ptr;
  assign o_addr = r_ptr[AW-1:0];
endmodule

// File: rtl/param_sync_fifo.sv
// param_sync_fifo: parametrised single-clock FIFO with registered flags.
//   clk, rst : clock, async active-high reset
//   bus      : param_sync_fifo_if.slave (write side, read side, flags, count)
// Parameters: DATA_W, DEPTH (power of two >= 2), AFULL_TH, AEMPTY_TH.
// Optional macro FIFO_ERR_FLAGS_EN: sticky ovf (write while full) and
// udf (read while empty) error flags, cleared only by rst.
// Read data is registered: rd_data/rd_valid appear one edge after rd_acc.
module param_sync_fifo
  import fifo_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int AFULL_TH  = DEPTH - 4,
  parameter int AEMPTY_TH = 4
) (
  input logic               clk,
  input logic               rst,
  param_sync_fifo_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  typedef logic [AW:0] ptr_t;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rd_data;
  logic              r_rd_valid;
  fifo_flags_t       r_flags;
  fifo_flags_t       w_flags_next;

  ptr_t              w_wr_ptr, w_rd_ptr;
  logic [AW-1:0]     w_wr_addr, w_rd_addr;
  ptr_t              w_count, w_count_next;
  logic              w_wr_acc, w_rd_acc;

  // Acceptance uses registered flags only: no rd_en -> write-accept path.
  assign w_wr_acc = bus.wr_en & ~r_flags.full;
  assign w_rd_acc = bus.rd_en & ~r_flags.empty;

  fifo_ptr #(.AW(AW)) u_wr_ptr (
    .clk(clk), .rst(rst), .i_inc(w_wr_acc), .o_ptr(w_wr_ptr), .o_addr(w_wr_addr)
  );

  fifo_ptr #(.AW(AW)) u_rd_ptr (
    .clk(clk), .rst(rst), .i_inc(w_rd_acc), .o_ptr(w_rd_ptr), .o_addr(w_rd_addr)
  );

  // Occupancy is the wrap-aware pointer distance; both pointers are
  // registers, so count changes on the same edge as the accepted op and
  // needs no counter of its own.
  assign w_count      = w_wr_ptr - w_rd_ptr;
  assign w_count_next = w_count + ptr_t'(w_wr_acc) - ptr_t'(w_rd_acc);

  always_comb begin
    w_flags_next        = FLAGS_RST;
    w_flags_next.full   = (w_count_next == ptr_t'(DEPTH));
    w_flags_next.empty  = (w_count_next == '0);
    w_flags_next.afull  = (32'(w_count_next) >= AFULL_TH);
    w_flags_next.aempty = (32'(w_count_next) <= AEMPTY_TH);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_flags <= FLAGS_RST;
    else     r_flags <= w_flags_next;
  end

  // Storage is deliberately not reset; empty gating keeps stale words unreadable.
  always_ff @(posedge clk) begin
    if (w_wr_acc) r_mem[w_wr_addr] <= bus.wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= w_rd_acc;
      if (w_rd_acc) r_rd_data <= r_mem[w_rd_addr];
    end
  end

`ifdef FIFO_ERR_FLAGS_EN
  logic r_ovf, r_udf;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
    end else begin
      if (bus.wr_en & r_flags.full)  r_ovf <= 1'b1;
      if (bus.rd_en & r_flags.empty) r_udf <= 1'b1;
    end
  end

  assign bus.ovf = r_ovf;
  assign bus.udf = r_udf;
`endif

  assign bus.full     = r_flags.full;
  assign bus.afull    = r_flags.afull;
  assign bus.empty    = r_flags.empty;
  assign bus.aempty   = r_flags.aempty;
  assign bus.count    = w_count;
  assign bus.rd_data  = r_rd_data;
  assign bus.rd_valid = r_rd_valid;
endmodule

// File: tb/tb_param_sync_fifo.sv
// Bench for param_sync_fifo at default geometry (8 bit x 256).
// Model: sb holds words stored in the FIFO; out_q holds words the DUT
// must present on rd_data, pushed when a read is driven and popped when
// rd_valid is observed.
module tb_param_sync_fifo;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 256;
  localparam int AF_TH  = DEPTH - 4;
  localparam int AE_TH  = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  param_sync_fifo_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

  param_sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AFULL_TH(AF_TH), .AEMPTY_TH(AE_TH))
    dut (.clk(clk), .rst(rst), .bus(bus.slave));

  logic [DATA_W-1:0] sb [$];
  logic [DATA_W-1:0] out_q [$];
  logic              exp_vld;
  logic              m_ovf, m_udf;
  int                n_chk = 0;
  int                n_fail = 0;

  // One clock with the given requests; updates the model from its pre-edge
  // state, then returns #1 after the edge with requests dropped.
  task automatic drive(input logic we, input logic [DATA_W-1:0] wd, input logic re);
    bit wa, ra;
    wa = we && (sb.size() < DEPTH);
    ra = re && (sb.size() > 0);
    if (we && sb.size() == DEPTH) m_ovf = 1'b1;
    if (re && sb.size() == 0)     m_udf = 1'b1;
    bus.wr_en = we; bus.wr_data = wd; bus.rd_en = re;
    if (ra) out_q.push_back(sb.pop_front());
    if (wa) sb.push_back(wd);
    exp_vld = ra;
    @(posedge clk); #1;
    bus.wr_en = 1'b0; bus.rd_en = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    sb.delete(); out_q.delete(); m_ovf = 0; m_udf = 0; exp_vld = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    n_chk++;
    if ({bus.full, bus.afull, bus.empty, bus.aempty} !== 4'b0011) begin
      n_fail++; $display("FAIL reset_flags got %b want 0011", {bus.full, bus.afull, bus.empty, bus.aempty});
    end
    n_chk++;
    if (bus.count !== '0 || bus.rd_valid !== 1'b0 || bus.rd_data !== '0) begin
      n_fail++; $display("FAIL reset_out count=%0d vld=%b data=%h want 0/0/00", bus.count, bus.rd_valid, bus.rd_data);
    end
`ifdef FIFO_ERR_FLAGS_EN
    n_chk++;
    if ({bus.ovf, bus.udf} !== 2'b00) begin
      n_fail++; $display("FAIL reset_err got %b want 00", {bus.ovf, bus.udf});
    end
`endif
  endtask

  task automatic test_fill;
    for (int i = 0; i < DEPTH; i++) begin
      int c;
      drive(1'b1, DATA_W'(i), 1'b0);
      c = i + 1;
      n_chk++;
      if (bus.count !== 9'(c)) begin
        n_fail++; $display("FAIL fill_count got %0d want %0d", bus.count, c);
      end
      n_chk++;
      if ({bus.full, bus.afull, bus.empty, bus.aempty} !== {c == DEPTH, c >= AF_TH, 1'b0, c <= AE_TH}) begin
        n_fail++; $display("FAIL fill_flags at count %0d got %b want %b", c,
          {bus.full, bus.afull, bus.empty, bus.aempty}, {c == DEPTH, c >= AF_TH, 1'b0, c <= AE_TH});
      end
    end
  endtask

  task automatic test_overflow;
    drive(1'b1, 8'hAA, 1'b0);
    n_chk++;
    if (bus.count !== 9'(DEPTH) || bus.full !== 1'b1) begin
      n_fail++; $display("FAIL ovf_count got %0d full=%b want 256 full=1", bus.count, bus.full);
    end
    drive(1'b0, '0, 1'b0);
`ifdef FIFO_ERR_FLAGS_EN
    n_chk++;
    if (bus.ovf !== m_ovf || m_ovf !== 1'b1) begin
      n_fail++; $display("FAIL ovf_sticky got %b want 1", bus.ovf);
    end
`endif
  endtask

  task automatic test_drain;
    logic [DATA_W-1:0] exp;
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b0, '0, 1'b1);
      exp = exp_vld ? out_q.pop_front() : 'x;
      n_chk++;
      if (bus.rd_valid !== 1'b1 || bus.rd_data !== exp || bus.count !== 9'(DEPTH - 1 - i)) begin
        n_fail++; $display("FAIL drain_word %0d got vld=%b data=%h cnt=%0d want 1/%h/%0d",
          i, bus.rd_valid, bus.rd_data, bus.count, exp, DEPTH - 1 - i);
      end
    end
    n_chk++;
    if (bus.empty !== 1'b1 || bus.aempty !== 1'b1 || bus.afull !== 1'b0) begin
      n_fail++; $display("FAIL drain_flags got e=%b ae=%b af=%b want 1/1/0", bus.empty, bus.aempty, bus.afull);
    end
    drive(1'b0, '0, 1'b1);
    n_chk++;
    if (bus.rd_valid !== 1'b0 || bus.rd_data !== 8'hFF || bus.count !== '0) begin
      n_fail++; $display("FAIL udf_read got vld=%b data=%h cnt=%0d want 0/ff/0", bus.rd_valid, bus.rd_data, bus.count);
    end
`ifdef FIFO_ERR_FLAGS_EN
    n_chk++;
    if (bus.udf !== m_udf || m_udf !== 1'b1) begin
      n_fail++; $display("FAIL udf_sticky got %b want 1", bus.udf);
    end
`endif
  endtask

  task automatic test_stream;
    logic [DATA_W-1:0] exp;
    logic [DATA_W-1:0] pat = 8'h30;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, pat, 1'b0);
      pat++;
    end
    for (int i = 0; i < 1000; i++) begin
      drive(1'b1, pat, 1'b1);
      pat++;
      exp = exp_vld ? out_q.pop_front() : 'x;
      n_chk++;
      if (bus.rd_valid !== 1'b1 || bus.rd_data !== exp || bus.count !== 9'd10) begin
        n_fail++; $display("FAIL stream %0d got vld=%b data=%h cnt=%0d want 1/%h/10",
          i, bus.rd_valid, bus.rd_data, bus.count, exp);
      end
    end
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, '0, 1'b1);
      exp = exp_vld ? out_q.pop_front() : 'x;
      n_chk++;
      if (bus.rd_valid !== 1'b1 || bus.rd_data !== exp) begin
        n_fail++; $display("FAIL stream_tail %0d got vld=%b data=%h want 1/%h", i, bus.rd_valid, bus.rd_data, exp);
      end
    end
  endtask

  task automatic test_empty_both;
    logic [DATA_W-1:0] exp;
    drive(1'b1, 8'h5C, 1'b1);
    n_chk++;
    if (bus.rd_valid !== 1'b0 || bus.count !== 9'd1 || bus.empty !== 1'b0) begin
      n_fail++; $display("FAIL empty_both got vld=%b cnt=%0d empty=%b want 0/1/0", bus.rd_valid, bus.count, bus.empty);
    end
    drive(1'b0, '0, 1'b1);
    exp = exp_vld ? out_q.pop_front() : 'x;
    n_chk++;
    if (bus.rd_valid !== 1'b1 || bus.rd_data !== exp || bus.count !== '0) begin
      n_fail++; $display("FAIL empty_both_rd got vld=%b data=%h cnt=%0d want 1/%h/0", bus.rd_valid, bus.rd_data, bus.count, exp);
    end
  endtask

  task automatic test_async_reset;
    logic [DATA_W-1:0] exp;
    for (int i = 0; i < 37; i++) drive(1'b1, DATA_W'(8'h80 + i), 1'b0);
    drive(1'b1, 8'hC0, 1'b1);
    void'(out_q.pop_front());
    n_chk++;
    if (bus.count !== 9'd37 || bus.rd_valid !== 1'b1) begin
      n_fail++; $display("FAIL pre_reset got cnt=%0d vld=%b want 37/1", bus.count, bus.rd_valid);
    end
    // Mid-cycle, well away from any clock edge.
    #2 rst = 1'b1;
    #1;
    n_chk++;
    if (bus.count !== '0 || bus.rd_valid !== 1'b0 || bus.rd_data !== '0 ||
        {bus.full, bus.afull, bus.empty, bus.aempty} !== 4'b0011) begin
      n_fail++; $display("FAIL async_reset got cnt=%0d vld=%b data=%h flags=%b want 0/0/00/0011",
        bus.count, bus.rd_valid, bus.rd_data, {bus.full, bus.afull, bus.empty, bus.aempty});
    end
`ifdef FIFO_ERR_FLAGS_EN
    n_chk++;
    if ({bus.ovf, bus.udf} !== 2'b00) begin
      n_fail++; $display("FAIL async_reset_err got %b want 00", {bus.ovf, bus.udf});
    end
`endif
    sb.delete(); out_q.delete(); m_ovf = 0; m_udf = 0; exp_vld = 0;
    @(posedge clk); #1 rst = 1'b0;
    drive(1'b1, 8'h11, 1'b0);
    drive(1'b0, '0, 1'b1);
    exp = exp_vld ? out_q.pop_front() : 'x;
    n_chk++;
    if (bus.rd_valid !== 1'b1 || bus.rd_data !== exp || exp !== 8'h11) begin
      n_fail++; $display("FAIL post_reset_rd got vld=%b data=%h want 1/11", bus.rd_valid, bus.rd_data);
    end
  endtask

  initial begin
    bus.wr_en = 1'b0; bus.wr_data = '0; bus.rd_en = 1'b0;
    test_reset;
    test_fill;
    test_overflow;
    test_drain;
    test_stream;
    test_empty_both;
    test_async_reset;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/param_sync_fifo.md
# param_sync_fifo

Parametrised single-clock FIFO: the successor to the fixed 8-bit/256-entry write-side block built from an address generator feeding a memory write port. It adds a read side, registered status flags, an occupancy count, programmable almost-full/almost-empty thresholds, and defined behaviour on overflow and underflow. It sits between a producer and a consumer in the same clock domain and is the standard buffering element for the partitioned datapath.

## Interface
- DATA_W, 8: word width in bits, ≥1.
- DEPTH, 256: number of entries; power of two, ≥2.
- AFULL_TH, DEPTH-4: afull asserts when count ≥ AFULL_TH.
- AEMPTY_TH, 4: aempty asserts when count ≤ AEMPTY_TH.
- AW, $clog2(DEPTH): derived local parameter, not overridable.

- clk  input  1  sole clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- wr_en  input  1  write request.
- wr_data  input  DATA_W  write word.
- full  output  1  no free entry.
- afull  output  1  count ≥ AFULL_TH.
- rd_en  input  1  read request.
- rd_data  output  DATA_W  registered read word.
- rd_valid  output  1  one-cycle pulse: rd_data holds a newly popped word.
- empty  output  1  no stored entry.
- aempty  output  1  count ≤ AEMPTY_TH.
- count  output  AW+1  current occupancy, 0..DEPTH.
- ovf  output  1  sticky overflow error (FIFO_ERR_FLAGS_EN only).
- udf  output  1  sticky underflow error (FIFO_ERR_FLAGS_EN only).

## Operation
- Write accept: wr_acc = wr_en & ~full. Read accept: rd_acc = rd_en & ~empty. Both are computed from registered flags only; there is no combinational path from rd_en to write acceptance.
- On wr_acc: mem[wr_ptr] ← wr_data; wr_ptr increments.
- On rd_acc: rd_data ← mem[rd_ptr]; rd_ptr increments.
- Pointers are AW+1 bits. The low AW bits address memory; the MSB is the wrap bit. Pointers wrap naturally from 2^(AW+1)-1 to 0.
- count next = count + wr_acc − rd_acc.
  - Both accepted: count is unchanged.
  - Empty with both requests: only the write is accepted.
  - Full with both requests: only the read is accepted.
- Flags are registered and derived from next count:
  - full = (count_next == DEPTH)
  - empty = (count_next == 0)
  - afull and aempty follow their thresholds.
- Rejected requests have no effect on memory, pointers or count.
- Memory array is not reset. Read of an unwritten location is impossible, because empty gates reads.
- Reset values: wr_ptr = 0, rd_ptr = 0, count = 0, empty = 1, aempty = 1, full = 0, afull = 0, rd_valid = 0, rd_data = 0, ovf = 0, udf = 0.
- Reset mid-operation: all of the above apply immediately (asynchronously). Stored data is discarded logically. The first post-reset read returns the first post-reset write.

## Timing
- Read latency is 1 cycle. When rd_acc occurs at edge N, rd_data is valid and rd_valid = 1 after edge N, for one cycle. rd_data holds its value until the next rd_acc.
- Write-to-read latency is 1 cycle. A word written at edge N deasserts empty after edge N. It can be read-accepted at edge N+1 and appears on rd_data after edge N+1. There is no write-to-read bypass.
- All flags and count update on the same edge as the accepted operation that changes them.
- Reset deassertion must be synchronous to clk externally; the first edge after deassertion is a normal operating edge.

## Configuration
- FIFO_ERR_FLAGS_EN defined:
  - ovf sets on wr_en & full.
  - udf sets on rd_en & empty.
  - Both stay set until rst.
- FIFO_ERR_FLAGS_EN undefined: ovf and udf ports are absent, no error logic is built, and rejected requests are silently dropped.

## Structure
- Package fifo_pkg holds:
  - the ptr_t typedef template convention (AW+1 wide);
  - a flag-struct typedef {full, afull, empty, aempty};
  - localparam defaults (DEF_DATA_W = 8, DEF_DEPTH = 256).
- Sub-module fifo_ptr is the generalised address generator: AW+1 bit counter with clk, rst, inc, and ptr/addr outputs. It is instantiated once for write and once for read.
- Memory is an inferred array inside param_sync_fifo.

## Test plan
- Reset, then write 0x00..0xFF on 256 consecutive cycles:
  - full asserts after the 256th edge, count = 256;
  - afull first asserts when count = 252;
  - empty falls after the first edge.
- From full, wr_en with 0xAA: count stays 256 and memory is unchanged. With FIFO_ERR_FLAGS_EN, ovf = 1 and stays 1.
- From full, read 256 words: rd_data sequence is 0x00..0xFF, each with rd_valid, 1 cycle after its rd_acc. empty and aempty are set at the end. An extra rd_en sets udf (macro on) with no rd_valid.
- Fill to count 10, then assert wr_en and rd_en for 1000 cycles with an incrementing pattern:
  - count stays 10;
  - pointers wrap multiple times;
  - output order matches input order.
- From empty, a single cycle with wr_en = rd_en = 1 and data 0x5C: write only, count = 1, rd_valid = 0. On the next cycle rd_en yields rd_data = 0x5C.
- Assert rst asynchronously mid-burst with count = 37: all outputs reach their reset values without a clock edge. The post-reset write of 0x11 followed by a read returns 0x11.
